// File: rtl/ex_mdu_unit.sv
// Iterative multiply/divide unit for the EX stage: 1-bit shift-add multiply and
// restoring divide, one iteration per cycle, owning the EX slot while busy.
module ex_mdu_unit #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [RA_W-1:0]  rd_addr_in,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [RA_W-1:0]  rd_addr_out
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_MULHU = 3'd1;
  localparam logic [2:0] OP_MULHS = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_DIVS  = 3'd4;
  localparam logic [2:0] OP_REMU  = 3'd5;
  localparam logic [2:0] OP_REMS  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             neg_q, sign_a_q;
  logic [RA_W-1:0]  rd_q;
  // hi/lo hold {product} for multiply and {remainder, dividend/quotient} for divide.
  logic [WIDTH-1:0] hi, lo;

  logic             in_div, in_signed, accept, div_zero;
  logic [WIDTH-1:0] a_mag_in, b_mag_in, zero_res;

  assign in_div    = (op >= OP_DIVU) && (op <= OP_REMS);
  assign in_signed = (op == OP_MULHS) || (op == OP_DIVS) || (op == OP_REMS);
  assign accept    = (state == IDLE) && start && (op != OP_RSVD) && !flush;
  assign div_zero  = in_div && (op_b == '0);
  assign a_mag_in  = (in_signed && op_a[WIDTH-1]) ? -op_a : op_a;
  assign b_mag_in  = (in_signed && op_b[WIDTH-1]) ? -op_b : op_b;
  assign zero_res  = ((op == OP_DIVU) || (op == OP_DIVS)) ? '1 : op_a;

  assign stall = accept || (state == CALC);
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

  logic             q_div;
  logic [WIDTH:0]   add_sum, shifted, diff;
  logic [WIDTH-1:0] next_hi, next_lo, quo_s, rem_s, final_res;
  logic [2*WIDTH-1:0] prod_s;

  assign q_div = (op_q >= OP_DIVU) && (op_q <= OP_REMS);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    add_sum = {1'b0, hi} + (lo[0] ? {1'b0, a_mag} : '0);
    shifted = {hi, lo[WIDTH-1]};
    diff    = shifted - {1'b0, b_mag};
    next_hi = add_sum[WIDTH:1];
    next_lo = {add_sum[0], lo[WIDTH-1:1]};
    if (q_div) begin
      // Trial subtraction; bit WIDTH of diff is the borrow (restore when set).
      if (!diff[WIDTH]) begin
        next_hi = diff[WIDTH-1:0];
        next_lo = {lo[WIDTH-2:0], 1'b1};
      end else begin
        next_hi = shifted[WIDTH-1:0];
        next_lo = {lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    prod_s    = neg_q ? -{next_hi, next_lo} : {next_hi, next_lo};
    quo_s     = neg_q ? -next_lo : next_lo;
    rem_s     = sign_a_q ? -next_hi : next_hi;
    final_res = '0;
    unique case (op_q)
      OP_MUL:             final_res = prod_s[WIDTH-1:0];
      OP_MULHU, OP_MULHS: final_res = prod_s[2*WIDTH-1:WIDTH];
      OP_DIVU, OP_DIVS:   final_res = quo_s;
      OP_REMU, OP_REMS:   final_res = rem_s;
      default:            final_res = '0;
    endcase
  end

  // NOTE: state and datapath registers use non-blocking assignments; every one,
  // datapath included, is cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      op_q        <= '0;
      a_mag       <= '0;
      b_mag       <= '0;
      neg_q       <= 1'b0;
      sign_a_q    <= 1'b0;
      rd_q        <= '0;
      hi          <= '0;
      lo          <= '0;
      result      <= '0;
      rd_addr_out <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          op_q     <= op;
          a_mag    <= a_mag_in;
          b_mag    <= b_mag_in;
          neg_q    <= in_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          sign_a_q <= in_signed && op_a[WIDTH-1];
          rd_q     <= rd_addr_in;
          hi       <= '0;
          lo       <= in_div ? a_mag_in : b_mag_in;
          if (div_zero) begin
            result      <= zero_res;
            rd_addr_out <= rd_addr_in;
            state       <= DONE;
          end else begin
            cnt   <= CW'(WIDTH);
            state <= CALC;
          end
        end
        CALC: if (flush) begin
          cnt   <= '0;
          state <= IDLE;
        end else begin
          hi  <= next_hi;
          lo  <= next_lo;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result      <= final_res;
            rd_addr_out <= rd_q;
            state       <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mdu_unit.sv
// Directed bench for ex_mdu_unit (WIDTH=32): vector table plus hand sequences
// for op 7, flush, flush-vs-start and asynchronous reset mid-operation.
module tb_ex_mdu_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst, start, flush;
  logic [2:0]    op;
  logic [W-1:0]  op_a, op_b, result;
  logic [4:0]    rd_addr_in, rd_addr_out;
  logic          stall, busy, done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  ex_mdu_unit #(.WIDTH(W), .RA_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .rd_addr_in(rd_addr_in), .flush(flush), .stall(stall), .busy(busy),
    .done(done), .result(result), .rd_addr_out(rd_addr_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (done === 1'b1) done_cnt++;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic [4:0]   rd;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one operation and follow it to done, checking latency and outputs.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [4:0] rd,
                        input logic [W-1:0] exp, input int exp_lat);
    int lat;
    bit stall_bad;
    @(negedge clk);
    op = o; op_a = a; op_b = b; rd_addr_in = rd; start = 1'b1;
    #1 check({tag, "_stall_start"}, stall, 1);
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    stall_bad = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (stall !== 1'b1 || busy !== 1'b1) stall_bad = 1;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_stall_calc"}, stall_bad, 0);
    check({tag, "_result"}, result, exp);
    check({tag, "_rd"}, rd_addr_out, rd);
    check({tag, "_stall_done"}, stall, 0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {done, busy}, 2'b00);
    check({tag, "_result_hold"}, result, exp);
  endtask

  initial begin
    int seen;
    vecs[0]  = '{3'd0, 32'd7,        32'd6,        5'd1,  32'h0000002A, 33};
    vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000000, 33};
    vecs[2]  = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'h00000001, 33};
    vecs[3]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE, 33};
    vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFD, 33};
    vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 33};
    vecs[6]  = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd7,  32'h80000000, 33};
    vecs[7]  = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd8,  32'h00000000, 33};
    vecs[8]  = '{3'd3, 32'd5,        32'd0,        5'd9,  32'hFFFFFFFF, 1};
    vecs[9]  = '{3'd5, 32'd5,        32'd0,        5'd10, 32'h00000005, 1};
    vecs[10] = '{3'd4, 32'hFFFFFFF9, 32'd0,        5'd11, 32'hFFFFFFFF, 1};
    vecs[11] = '{3'd6, 32'hFFFFFFF9, 32'd0,        5'd12, 32'hFFFFFFF9, 1};
    vecs[12] = '{3'd2, 32'hFFFFFFFE, 32'd3,        5'd13, 32'hFFFFFFFF, 33};
    vecs[13] = '{3'd0, 32'hFFFFFFFE, 32'd3,        5'd14, 32'hFFFFFFFA, 33};
    vecs[14] = '{3'd1, 32'h80000000, 32'd4,        5'd15, 32'h00000002, 33};
    vecs[15] = '{3'd2, 32'h80000000, 32'h80000000, 5'd16, 32'h40000000, 33};
    vecs[16] = '{3'd3, 32'd100,      32'd7,        5'd17, 32'h0000000E, 33};
    vecs[17] = '{3'd5, 32'd100,      32'd7,        5'd18, 32'h00000002, 33};
    vecs[18] = '{3'd4, 32'd7,        32'hFFFFFFFE, 5'd19, 32'hFFFFFFFD, 33};
    vecs[19] = '{3'd6, 32'd7,        32'hFFFFFFFE, 5'd20, 32'h00000001, 33};
    vecs[20] = '{3'd3, 32'hFFFFFFFF, 32'd1,        5'd21, 32'hFFFFFFFF, 33};
    vecs[21] = '{3'd5, 32'hFFFFFFFF, 32'h10,       5'd22, 32'h0000000F, 33};

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; op_a = '0; op_b = '0; rd_addr_in = '0;
    #1 check("reset_outputs", {stall, busy, done, result, rd_addr_out}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i])
      run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].rd, vecs[i].exp, vecs[i].lat);

    // Reserved op: ignored, no stall.
    seen = done_cnt;
    @(negedge clk);
    op = 3'd7; op_a = 32'd9; op_b = 32'd3; start = 1'b1;
    #1 check("op7_stall", stall, 0);
    @(posedge clk); #1;
    start = 1'b0;
    check("op7_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 check("op7_no_done", done_cnt, seen);

    // Flush wins over start in IDLE.
    @(negedge clk);
    op = 3'd3; op_a = 32'd9; op_b = 32'd3; start = 1'b1; flush = 1'b1;
    #1 check("flush_start_stall", stall, 0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", busy, 0);

    // DIVU 100/3 flushed in cycle 10, restarted in cycle 11.
    seen = done_cnt;
    @(negedge clk);
    op = 3'd3; op_a = 32'd100; op_b = 32'd3; rd_addr_in = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    check("flush_busy_before", busy, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_after", {busy, stall, done}, 3'b000);
    check("flush_no_done", done_cnt, seen);
    run_op("after_flush", 3'd3, 32'd100, 32'd3, 5'd3, 32'd33, 33);

    // Asynchronous reset during a MULHU.
    seen = done_cnt;
    @(negedge clk);
    op = 3'd1; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF; rd_addr_in = 5'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("rst_mid_outputs", {stall, busy, done, result, rd_addr_out}, '0);
    @(negedge clk);
    rst = 1'b0;
    check("rst_no_done", done_cnt, seen);
    run_op("after_rst", 3'd1, 32'h80000000, 32'd4, 5'h1F, 32'h00000002, 33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
